// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_pkg
// Shared definitions for the ALU sequencing controller:
//   - FSM state encoding (IDLE/READ/SHIFT/EXEC/WB)
//   - ALU operation codes, including the flag-only compare range 8..11
//   - shifter operation codes
//   - bit positions of N, Z, C, V inside a 4-bit flag vector
// -----------------------------------------------------------------------------
package alu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_EOR = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_RSB = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_ADC = 4'd5;
    localparam logic [3:0] ALU_SBC = 4'd6;
    localparam logic [3:0] ALU_RSC = 4'd7;
    localparam logic [3:0] ALU_TST = 4'd8;
    localparam logic [3:0] ALU_TEQ = 4'd9;
    localparam logic [3:0] ALU_CMP = 4'd10;
    localparam logic [3:0] ALU_CMN = 4'd11;
    localparam logic [3:0] ALU_ORR = 4'd12;
    localparam logic [3:0] ALU_MOV = 4'd13;
    localparam logic [3:0] ALU_BIC = 4'd14;
    localparam logic [3:0] ALU_MVN = 4'd15;

    localparam logic [3:0] ALU_CMP_LO = 4'd8;
    localparam logic [3:0] ALU_CMP_HI = 4'd11;

    localparam logic [2:0] SHIFT_LSL = 3'd0;
    localparam logic [2:0] SHIFT_LSR = 3'd1;
    localparam logic [2:0] SHIFT_ASR = 3'd2;
    localparam logic [2:0] SHIFT_ROR = 3'd3;
    localparam logic [2:0] SHIFT_RRX = 3'd4;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Compare-class ops only produce flags and never write the destination.
    function automatic logic is_compare(input logic [3:0] op);
        return (op >= ALU_CMP_LO) && (op <= ALU_CMP_HI);
    endfunction

endpackage

// File: rtl/alu_seq_fsm.sv
// -----------------------------------------------------------------------------
// alu_seq_fsm
// Sequencing state machine: IDLE -> READ -> SHIFT -> EXEC -> WB -> IDLE.
// A command is taken only in IDLE; every other state lasts exactly one cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cmd_valid  : command offered by upstream
//   state      : current state (registered)
//   cmd_ready  : high in IDLE while reset is released
//   busy       : registered, high in every non-IDLE state
// -----------------------------------------------------------------------------
module alu_seq_fsm
    import alu_seq_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   cmd_valid,
    output state_t state,
    output logic   cmd_ready,
    output logic   busy
);

    // Ready is qualified with rst so it reads low for the whole reset pulse.
    assign cmd_ready = (state == ST_IDLE) && !rst;

    // State register with next-state decode; busy tracks the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_READ;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_READ: begin
                    state <= ST_SHIFT;
                    busy  <= 1'b1;
                end
                ST_SHIFT: begin
                    state <= ST_EXEC;
                    busy  <= 1'b1;
                end
                ST_EXEC: begin
                    state <= ST_WB;
                    busy  <= 1'b1;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequences one data-processing command through an external register file,
// barrel shifter and ALU: read operands, shift, execute, write back.
// Every per-state output is a register loaded on the edge that enters its
// state and cleared on the edge that leaves it, so it is valid for exactly
// that state and 0 otherwise.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_*                    : command handshake and fields (latched on accept)
//   r_addr_a/b/c, r_data_a/b/c : register-file read (Rn, Rm, Rs), valid in READ
//   shift_*                  : shifter request (valid in SHIFT) and result
//   alu_*                    : ALU request (valid in EXEC) and result
//   w_addr, w_data, write_reg: write-back, valid in WB
//   nzcv                     : architectural flags (N,Z,C,V)
//   done, busy               : completion pulse in WB, busy in non-IDLE states
// Configuration:
//   ALU_SEQ_OPCNT_EN         : adds op_count, a 16-bit wrapping count of WBs
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_alu_op,
    input  logic [2:0]   cmd_shift_op,
    input  logic         cmd_shift_reg,
    input  logic [7:0]   cmd_shift_imm,
    input  logic         cmd_s,
    input  logic [3:0]   cmd_rn,
    input  logic [3:0]   cmd_rm,
    input  logic [3:0]   cmd_rs,
    input  logic [3:0]   cmd_rd,
    output logic [3:0]   r_addr_a,
    output logic [3:0]   r_addr_b,
    output logic [3:0]   r_addr_c,
    input  logic [W-1:0] r_data_a,
    input  logic [W-1:0] r_data_b,
    input  logic [W-1:0] r_data_c,
    output logic [W-1:0] shift_data,
    output logic [7:0]   shift_num,
    output logic [2:0]   shift_op,
    output logic         shift_cin,
    input  logic [W-1:0] shift_out,
    input  logic         shift_cout,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_scout,
    output logic         alu_c,
    output logic         alu_v,
    input  logic [W-1:0] alu_f,
    input  logic [3:0]   alu_nzcv,
    output logic [3:0]   w_addr,
    output logic [W-1:0] w_data,
    output logic         write_reg,
    output logic [3:0]   nzcv,
    output logic         done,
    output logic         busy
`ifdef ALU_SEQ_OPCNT_EN
    ,
    output logic [15:0]  op_count
`endif
);

    state_t state;

    // Latched command fields. Rn/Rm/Rs go straight into r_addr_*.
    logic [3:0] alu_op_r;
    logic [2:0] shift_op_r;
    logic       shift_reg_r;
    logic [7:0] shift_imm_r;
    logic       s_r;
    logic [3:0] rd_r;

    // Operand A held from READ until it is handed to the ALU.
    logic [W-1:0] op_a_r;
    // ALU flags held from EXEC until the WB -> IDLE edge.
    logic [3:0]   flags_r;

    // Only the low byte of Rs is a shift count; the rest is ignored.
    logic unused_rs_bits;
    assign unused_rs_bits = ^r_data_c[W-1:8];

    alu_seq_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .state     (state),
        .cmd_ready (cmd_ready),
        .busy      (busy)
    );

    // Datapath latches and per-state registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_r    <= 4'd0;
            shift_op_r  <= 3'd0;
            shift_reg_r <= 1'b0;
            shift_imm_r <= 8'd0;
            s_r         <= 1'b0;
            rd_r        <= 4'd0;
            op_a_r      <= '0;
            flags_r     <= 4'd0;
            r_addr_a    <= 4'd0;
            r_addr_b    <= 4'd0;
            r_addr_c    <= 4'd0;
            shift_data  <= '0;
            shift_num   <= 8'd0;
            shift_op    <= 3'd0;
            shift_cin   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 4'd0;
            alu_scout   <= 1'b0;
            alu_c       <= 1'b0;
            alu_v       <= 1'b0;
            w_addr      <= 4'd0;
            w_data      <= '0;
            write_reg   <= 1'b0;
            done        <= 1'b0;
            nzcv        <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Accept condition matches the FSM's IDLE -> READ edge.
                    if (cmd_valid) begin
                        alu_op_r    <= cmd_alu_op;
                        shift_op_r  <= cmd_shift_op;
                        shift_reg_r <= cmd_shift_reg;
                        shift_imm_r <= cmd_shift_imm;
                        s_r         <= cmd_s;
                        rd_r        <= cmd_rd;
                        r_addr_a    <= cmd_rn;
                        r_addr_b    <= cmd_rm;
                        r_addr_c    <= cmd_rs;
                    end else begin
                        r_addr_a    <= 4'd0;
                        r_addr_b    <= 4'd0;
                        r_addr_c    <= 4'd0;
                    end
                end
                ST_READ: begin
                    op_a_r     <= r_data_a;
                    // shift_data doubles as the operand-B latch.
                    shift_data <= r_data_b;
                    // Counts of 32 and above pass through untouched.
                    shift_num  <= shift_reg_r ? r_data_c[7:0] : shift_imm_r;
                    shift_op   <= shift_op_r;
                    shift_cin  <= nzcv[NZCV_C];
                    r_addr_a   <= 4'd0;
                    r_addr_b   <= 4'd0;
                    r_addr_c   <= 4'd0;
                end
                ST_SHIFT: begin
                    // alu_b/alu_scout capture the shifter result for EXEC.
                    alu_a      <= op_a_r;
                    alu_b      <= shift_out;
                    alu_op     <= alu_op_r;
                    alu_scout  <= shift_cout;
                    alu_c      <= nzcv[NZCV_C];
                    alu_v      <= nzcv[NZCV_V];
                    shift_data <= '0;
                    shift_num  <= 8'd0;
                    shift_op   <= 3'd0;
                    shift_cin  <= 1'b0;
                end
                ST_EXEC: begin
                    flags_r   <= alu_nzcv;
                    done      <= 1'b1;
                    if (is_compare(alu_op_r)) begin
                        write_reg <= 1'b0;
                        w_addr    <= 4'd0;
                        w_data    <= '0;
                    end else begin
                        write_reg <= 1'b1;
                        w_addr    <= rd_r;
                        w_data    <= alu_f;
                    end
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_op    <= 4'd0;
                    alu_scout <= 1'b0;
                    alu_c     <= 1'b0;
                    alu_v     <= 1'b0;
                end
                ST_WB: begin
                    done      <= 1'b0;
                    write_reg <= 1'b0;
                    w_addr    <= 4'd0;
                    w_data    <= '0;
                    if (s_r || is_compare(alu_op_r)) begin
                        nzcv <= flags_r;
                    end else begin
                        nzcv <= nzcv;
                    end
                end
                default: begin
                    done      <= 1'b0;
                    write_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    // Completed-command counter, bumped on the edge leaving WB; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (state == ST_WB) begin
            op_count <= op_count + 16'd1;
        end else begin
            op_count <= op_count;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_alu_op;
    logic [2:0]  cmd_shift_op;
    logic        cmd_shift_reg;
    logic [7:0]  cmd_shift_imm;
    logic        cmd_s;
    logic [3:0]  cmd_rn, cmd_rm, cmd_rs, cmd_rd;
    logic [3:0]  r_addr_a, r_addr_b, r_addr_c;
    logic [31:0] r_data_a, r_data_b, r_data_c;
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic        shift_cin;
    logic [31:0] shift_out;
    logic        shift_cout;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_scout, alu_c, alu_v;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        write_reg;
    logic [3:0]  nzcv;
    logic        done;
    logic        busy;
`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] op_count;
    logic [15:0] opcnt_m = 16'd0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference state: register file contents and architectural flags.
    logic [31:0] regs [16];
    logic [3:0]  nzcv_m;

    // Values observed from the DUT in the last command, for directed checks.
    logic [31:0] last_wdata;
    logic [7:0]  last_shnum;
    logic        last_wr;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_alu_op(cmd_alu_op), .cmd_shift_op(cmd_shift_op),
        .cmd_shift_reg(cmd_shift_reg), .cmd_shift_imm(cmd_shift_imm),
        .cmd_s(cmd_s), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_addr_c(r_addr_c),
        .r_data_a(r_data_a), .r_data_b(r_data_b), .r_data_c(r_data_c),
        .shift_data(shift_data), .shift_num(shift_num), .shift_op(shift_op),
        .shift_cin(shift_cin), .shift_out(shift_out), .shift_cout(shift_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_scout(alu_scout),
        .alu_c(alu_c), .alu_v(alu_v), .alu_f(alu_f), .alu_nzcv(alu_nzcv),
        .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg),
        .nzcv(nzcv), .done(done), .busy(busy)
`ifdef ALU_SEQ_OPCNT_EN
        , .op_count(op_count)
`endif
    );

    // Environment shifter: returns {carry_out, result}.
    function automatic logic [32:0] env_shift(input logic [31:0] d, input logic [7:0] n,
                                              input logic [2:0] op, input logic ci);
        logic [63:0] t;
        logic [31:0] o;
        logic [4:0]  k;
        case (op)
            3'd0: begin t = {32'd0, d} << n; return {(n == 8'd0) ? ci : t[32], t[31:0]}; end
            3'd1: begin t = {d, 32'd0} >> n; return {(n == 8'd0) ? ci : t[31], t[63:32]}; end
            3'd2: begin
                t = 64'($signed({d, 32'd0}) >>> n);
                return {(n == 8'd0) ? ci : t[31], t[63:32]};
            end
            3'd3: begin
                k = n[4:0];
                o = (d >> k) | (d << (6'd32 - {1'b0, k}));
                return {(n == 8'd0) ? ci : o[31], o};
            end
            3'd4: return {d[0], ci, d[31:1]};
            default: return {ci, d};
        endcase
    endfunction

    // Adder helper: returns {overflow, carry, sum}.
    function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] r;
        r = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        return {(x[31] == y[31]) && (r[31] != x[31]), r};
    endfunction

    // Environment ALU: returns {nzcv, result}.
    function automatic logic [35:0] env_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic sc,
                                            input logic c, input logic v);
        logic [33:0] r;
        logic [31:0] f;
        logic cc, vv;
        bit arith;
        arith = 1'b1;
        r = 34'd0;
        f = 32'd0;
        case (op)
            4'd2, 4'd10: r = add3(a, ~b, 1'b1);
            4'd3:        r = add3(b, ~a, 1'b1);
            4'd4, 4'd11: r = add3(a, b, 1'b0);
            4'd5:        r = add3(a, b, c);
            4'd6:        r = add3(a, ~b, c);
            4'd7:        r = add3(b, ~a, c);
            default: begin
                arith = 1'b0;
                case (op)
                    4'd0, 4'd8: f = a & b;
                    4'd1, 4'd9: f = a ^ b;
                    4'd12:      f = a | b;
                    4'd13:      f = b;
                    4'd14:      f = a & ~b;
                    default:    f = ~b;
                endcase
            end
        endcase
        if (arith) begin
            f = r[31:0]; cc = r[32]; vv = r[33];
        end else begin
            cc = sc; vv = v;
        end
        return {f[31], (f == 32'd0), cc, vv, f};
    endfunction

    assign r_data_a = regs[r_addr_a];
    assign r_data_b = regs[r_addr_b];
    assign r_data_c = regs[r_addr_c];
    assign {shift_cout, shift_out} = env_shift(shift_data, shift_num, shift_op, shift_cin);
    assign {alu_nzcv, alu_f} = env_alu(alu_a, alu_b, alu_op, alu_scout, alu_c, alu_v);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command from an IDLE negedge to the next IDLE negedge.
    // keep=1 leaves cmd_valid high and scrambles the fields while busy.
    task automatic issue(input logic [3:0] aop, input logic [2:0] sop, input logic sreg,
                         input logic [7:0] imm, input logic s, input logic [3:0] rn,
                         input logic [3:0] rm, input logic [3:0] rs, input logic [3:0] rd,
                         input bit keep);
        logic [7:0]  cnt;
        logic [32:0] shr;
        logic [35:0] alr;
        logic [31:0] a_val, b_val;
        bit cmp;
        cnt   = sreg ? regs[rs][7:0] : imm;
        a_val = regs[rn];
        b_val = regs[rm];
        shr   = env_shift(b_val, cnt, sop, nzcv_m[1]);
        alr   = env_alu(a_val, shr[31:0], aop, shr[32], nzcv_m[1], nzcv_m[0]);
        cmp   = (aop >= 4'd8) && (aop <= 4'd11);

        cmd_alu_op = aop; cmd_shift_op = sop; cmd_shift_reg = sreg; cmd_shift_imm = imm;
        cmd_s = s; cmd_rn = rn; cmd_rm = rm; cmd_rs = rs; cmd_rd = rd; cmd_valid = 1'b1;
        chk("idle_ready", 64'(cmd_ready), 64'd1);

        @(negedge clk);  // READ
        chk("read_busy", 64'(busy), 64'd1);
        chk("read_ready", 64'(cmd_ready), 64'd0);
        chk("read_done", 64'(done), 64'd0);
        chk("read_addr", 64'({r_addr_a, r_addr_b, r_addr_c}), 64'({rn, rm, rs}));
        if (keep) begin
            cmd_alu_op = 4'($urandom_range(0, 15)); cmd_rn = 4'($urandom_range(0, 15));
            cmd_rm = 4'($urandom_range(0, 15)); cmd_rd = 4'($urandom_range(0, 15));
            cmd_shift_imm = 8'($urandom_range(0, 255)); cmd_s = ~s;
        end else begin
            cmd_valid = 1'b0;
        end

        @(negedge clk);  // SHIFT
        last_shnum = shift_num;
        chk("shift_num", 64'(shift_num), 64'(cnt));
        chk("shift_data", 64'(shift_data), 64'(b_val));
        chk("shift_op", 64'(shift_op), 64'(sop));
        chk("shift_ready", 64'(cmd_ready), 64'd0);
        chk("shift_done", 64'(done), 64'd0);

        @(negedge clk);  // EXEC
        chk("exec_alu", 64'({alu_a, alu_b}), {a_val, shr[31:0]});
        chk("exec_ctl", 64'({alu_op, alu_scout, alu_c, alu_v}),
            64'({aop, shr[32], nzcv_m[1], nzcv_m[0]}));
        chk("exec_done", 64'({done, write_reg}), 64'd0);

        @(negedge clk);  // WB
        last_wdata = w_data;
        last_wr    = write_reg;
        chk("wb_done", 64'(done), 64'd1);
        chk("wb_write", 64'(write_reg), 64'(!cmp));
        if (!cmp) begin
            chk("wb_addr", 64'(w_addr), 64'(rd));
            chk("wb_data", 64'(w_data), 64'(alr[31:0]));
            regs[rd] = alr[31:0];
        end
        if (s || cmp) nzcv_m = alr[35:32];
`ifdef ALU_SEQ_OPCNT_EN
        opcnt_m = opcnt_m + 16'd1;
`endif

        @(negedge clk);  // back in IDLE
        chk("post_pulse", 64'({done, write_reg, busy}), 64'd0);
        chk("post_ready", 64'(cmd_ready), 64'd1);
        chk("post_nzcv", 64'(nzcv), 64'(nzcv_m));
`ifdef ALU_SEQ_OPCNT_EN
        chk("op_count", 64'(op_count), 64'(opcnt_m));
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[1] = 32'd5; regs[2] = 32'd3; regs[4] = 32'h108; regs[7] = 32'h1234;
        nzcv_m = 4'd0;
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_alu_op = 4'd0; cmd_shift_op = 3'd0; cmd_shift_reg = 1'b0; cmd_shift_imm = 8'd0;
        cmd_s = 1'b0; cmd_rn = 4'd0; cmd_rm = 4'd0; cmd_rs = 4'd0; cmd_rd = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_outs", 64'({busy, done, write_reg, nzcv}), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(cmd_ready), 64'd1);

        // ADD r3 = r1 + (r2 LSL 2), flags set
        issue(4'd4, 3'd0, 1'b0, 8'd2, 1'b1, 4'd1, 4'd2, 4'd0, 4'd3, 1'b0);
        chk("add_wdata", 64'(last_wdata), 64'd17);
        chk("add_nzcv", 64'(nzcv), 64'd0);

        // CMP r7, r7: no write, Z and C set
        issue(4'd10, 3'd0, 1'b0, 8'd0, 1'b0, 4'd7, 4'd7, 4'd0, 4'd9, 1'b0);
        chk("cmp_wr", 64'(last_wr), 64'd0);
        chk("cmp_nzcv", 64'(nzcv), 64'h6);

        // Register-specified shift: count from low byte of r4 = 0x108
        issue(4'd13, 3'd0, 1'b1, 8'hFF, 1'b0, 4'd0, 4'd2, 4'd4, 4'd5, 1'b0);
        chk("regshift_num", 64'(last_shnum), 64'h08);

        // Large immediate count reaches the shifter unchanged
        issue(4'd13, 3'd1, 1'b0, 8'd200, 1'b1, 4'd0, 4'd7, 4'd0, 4'd6, 1'b0);
        chk("bigcnt_num", 64'(last_shnum), 64'd200);

        // Reset during EXEC aborts the command without write or flag change
        issue(4'd10, 3'd0, 1'b0, 8'd0, 1'b0, 4'd7, 4'd7, 4'd0, 4'd0, 1'b0);
        cmd_alu_op = 4'd4; cmd_shift_op = 3'd0; cmd_shift_reg = 1'b0; cmd_shift_imm = 8'd0;
        cmd_s = 1'b1; cmd_rn = 4'd1; cmd_rm = 4'd1; cmd_rd = 4'd8; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);  // EXEC
        rst = 1'b1;
        #1;
        chk("abort_state", 64'({busy, cmd_ready, done, write_reg}), 64'd0);
        chk("abort_nzcv", 64'(nzcv), 64'd0);
        nzcv_m = 4'd0;
`ifdef ALU_SEQ_OPCNT_EN
        opcnt_m = 16'd0;
`endif
        @(negedge clk);
        chk("abort_wr", 64'(write_reg), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        // First command after release; reads r8 to expose any stray write
        issue(4'd13, 3'd0, 1'b0, 8'd0, 1'b1, 4'd0, 4'd8, 4'd0, 4'd10, 1'b0);

        // cmd_valid held high across back-to-back commands
        issue(4'd4, 3'd0, 1'b0, 8'd1, 1'b1, 4'd1, 4'd2, 4'd0, 4'd11, 1'b1);
        issue(4'd2, 3'd3, 1'b0, 8'd4, 1'b1, 4'd11, 4'd7, 4'd0, 4'd12, 1'b1);
        issue(4'd0, 3'd2, 1'b1, 8'd0, 1'b0, 4'd12, 4'd7, 4'd4, 4'd11, 1'b1);
        issue(4'd11, 3'd4, 1'b0, 8'd0, 1'b0, 4'd11, 4'd12, 4'd0, 4'd0, 1'b0);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
